// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: capture FSM encoding, default
// FIFO depth and the bit positions of the receive status word on io_din.
package uart_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  localparam int unsigned DEFAULT_DEPTH_LOG2 = 4;

  localparam int unsigned STAT_NOT_EMPTY   = 0;
  localparam int unsigned STAT_FULL        = 1;
  localparam int unsigned STAT_OVERFLOW    = 2;
  localparam int unsigned STAT_ALMOST_FULL = 3;

  // Packs the receive status flags for the I/O read mux.
  function automatic logic [3:0] rx_status(input logic not_empty, input logic full,
                                           input logic overflow, input logic almost_full);
    logic [3:0] s;
    s = '0;
    s[STAT_NOT_EMPTY]   = not_empty;
    s[STAT_FULL]        = full;
    s[STAT_OVERFLOW]    = overflow;
    s[STAT_ALMOST_FULL] = almost_full;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// UART-side handshake plus CPU-side pop/status bundle for uart_rx_fifo.
// almost_full exists only when UART_RX_FIFO_WATERMARK_EN is defined.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int unsigned WIDTH      = 8
);
  logic                  rx_valid;
  logic [WIDTH-1:0]      rx_data;
  logic                  rx_rd;
  logic                  pop;
  logic [WIDTH-1:0]      dout;
  logic                  not_empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  clr_ovf;
`ifdef UART_RX_FIFO_WATERMARK_EN
  logic                  almost_full;
`endif

  modport master (
    output rx_valid, rx_data, pop, clr_ovf,
    input  rx_rd, dout, not_empty, full, count, overflow
`ifdef UART_RX_FIFO_WATERMARK_EN
    , input almost_full
`endif
  );

  modport slave (
    input  rx_valid, rx_data, pop, clr_ovf,
    output rx_rd, dout, not_empty, full, count, overflow
`ifdef UART_RX_FIFO_WATERMARK_EN
    , output almost_full
`endif
  );

endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between buart and the J1 I/O read path: acknowledges each UART
// byte with a one-cycle rx_rd pulse and queues it. Option: UART_RX_FIFO_WATERMARK_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int unsigned WIDTH      = 8
`ifdef UART_RX_FIFO_WATERMARK_EN
  , parameter int unsigned WATERMARK = 12
`endif
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [0:0]            state_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  rx_rd_q;
  logic                  ovf_q;
  logic                  full_w;
  logic                  not_empty_w;
  logic                  capture;
  logic                  do_push;
  logic                  do_pop;
  logic                  drop;
  logic [WIDTH-1:0]      rdata;

  assign full_w      = (count_q == CNT_FULL);
  assign not_empty_w = (count_q != '0);

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign capture = (state_q == ST_IDLE) && bus.rx_valid;
  assign do_pop  = bus.pop && not_empty_w;
  assign do_push = capture && (!full_w || do_pop);
  assign drop    = capture && full_w && !do_pop;

  always_comb begin
    count_nxt = count_q;
    if (do_push && !do_pop)      count_nxt = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_nxt = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rx_rd_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rx_rd_q <= capture;
      case (state_q)
        ST_IDLE: if (bus.rx_valid) state_q <= ST_ACK;
        default: if (!bus.rx_valid) state_q <= ST_IDLE;
      endcase
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_nxt;
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_WATERMARK_EN
  localparam logic [DEPTH_LOG2:0] WM = WATERMARK[DEPTH_LOG2:0];
  logic af_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) af_q <= 1'b0;
    else       af_q <= (count_nxt >= WM);
  end

  assign bus.almost_full = af_q;
`endif

  fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr_q),
    .wdata (bus.rx_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign bus.rx_rd     = rx_rd_q;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.not_empty = not_empty_w;
  assign bus.overflow  = ovf_q;
  assign bus.dout      = not_empty_w ? rdata : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queue on capture and are
// compared against dout on every pop.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(4), .WIDTH(8)) bus ();

`ifdef UART_RX_FIFO_WATERMARK_EN
  uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8), .WATERMARK(12)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  logic [7:0] sb [$];
  bit mov = 1'b0;
  int errors = 0;
  int checks = 0;

  task automatic send(input logic [7:0] b, input int unsigned hold, input bit with_pop, input bit with_clr);
    bit dropped;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.pop      = with_pop;
    bus.clr_ovf  = with_clr;
    if (with_pop && sb.size() > 0) begin
      checks++;
      if (bus.dout !== sb[0]) begin
        errors++; $display("FAIL send_head: dout=%h expected %h", bus.dout, sb[0]);
      end
    end
    @(posedge clk); #1;
    bus.pop = 1'b0;
    bus.clr_ovf = 1'b0;
    if (with_pop && sb.size() > 0) void'(sb.pop_front());
    dropped = (sb.size() >= 16);
    if (!dropped) sb.push_back(b);
    if (dropped) mov = 1'b1;
    else if (with_clr) mov = 1'b0;
    checks++;
    if (bus.rx_rd !== 1'b1) begin
      errors++; $display("FAIL rx_rd_pulse: rx_rd=%b expected 1 (byte %h)", bus.rx_rd, b);
    end
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rx_rd !== 1'b0) begin
        errors++; $display("FAIL rx_rd_hold: rx_rd=%b expected 0 (hold cycle %0d)", bus.rx_rd, i);
      end
    end
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.rx_rd !== 1'b0) begin
      errors++; $display("FAIL rx_rd_end: rx_rd=%b expected 0", bus.rx_rd);
    end
  endtask

  task automatic do_pop();
    bus.pop = 1'b1;
    checks++;
    if (sb.size() > 0) begin
      if (bus.dout !== sb[0]) begin
        errors++; $display("FAIL pop_data: dout=%h expected %h", bus.dout, sb[0]);
      end
    end else if (bus.dout !== 8'h00) begin
      errors++; $display("FAIL pop_empty_dout: dout=%h expected 00", bus.dout);
    end
    @(posedge clk); #1;
    bus.pop = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.rx_rd, bus.not_empty, bus.full, bus.overflow} !== 4'b0000 || bus.count !== 5'd0 || bus.dout !== 8'h00) begin
      errors++; $display("FAIL reset_state: rd/ne/full/ovf=%b count=%0d dout=%h expected 0000/0/00",
                         {bus.rx_rd, bus.not_empty, bus.full, bus.overflow}, bus.count, bus.dout);
    end
  endtask

  task automatic test_single_byte();
    send(8'h41, 0, 1'b0, 1'b0);
    checks++;
    if (bus.count !== 5'd1 || bus.dout !== 8'h41 || bus.not_empty !== 1'b1) begin
      errors++; $display("FAIL single_push: count=%0d dout=%h ne=%b expected 1/41/1", bus.count, bus.dout, bus.not_empty);
    end
    do_pop();
    checks++;
    if (bus.count !== 5'd0 || bus.dout !== 8'h00 || bus.not_empty !== 1'b0) begin
      errors++; $display("FAIL single_pop: count=%0d dout=%h ne=%b expected 0/00/0", bus.count, bus.dout, bus.not_empty);
    end
  endtask

  task automatic test_hold_valid();
    send(8'h33, 5, 1'b0, 1'b0);
    checks++;
    if (bus.count !== 5'(sb.size())) begin
      errors++; $display("FAIL hold_count: count=%0d expected %0d", bus.count, sb.size());
    end
    while (sb.size() > 0) do_pop();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) send(8'(i), 0, 1'b0, 1'b0);
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL fill16: full=%b count=%0d ovf=%b expected 1/16/0", bus.full, bus.count, bus.overflow);
    end
    send(8'hAA, 0, 1'b0, 1'b0);
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== mov) begin
      errors++; $display("FAIL drop: full=%b count=%0d ovf=%b expected 1/16/%b", bus.full, bus.count, bus.overflow, mov);
    end
    for (int i = 0; i < 16; i++) do_pop();
    checks++;
    if (bus.count !== 5'd0 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL drain: count=%0d ovf=%b expected 0/1", bus.count, bus.overflow);
    end
    bus.clr_ovf = 1'b1; @(posedge clk); #1; bus.clr_ovf = 1'b0; mov = 1'b0;
    checks++;
    if (bus.overflow !== mov) begin
      errors++; $display("FAIL clr_ovf: ovf=%b expected 0", bus.overflow);
    end
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 0, 1'b0, 1'b0);
    send(8'h99, 0, 1'b0, 1'b1);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++; $display("FAIL set_wins: ovf=%b expected 1", bus.overflow);
    end
    bus.clr_ovf = 1'b1; @(posedge clk); #1; bus.clr_ovf = 1'b0; mov = 1'b0;
    send(8'h55, 0, 1'b1, 1'b0);
    checks++;
    if (bus.overflow !== 1'b0 || bus.count !== 5'd16 || bus.full !== 1'b1) begin
      errors++; $display("FAIL pop_push_full: ovf=%b count=%0d full=%b expected 0/16/1", bus.overflow, bus.count, bus.full);
    end
    checks++;
    if (sb[15] !== 8'h55) begin
      errors++; $display("FAIL sb_tail: tail=%h expected 55", sb[15]);
    end
    while (sb.size() > 0) do_pop();
  endtask

  task automatic test_pop_empty();
    for (int i = 0; i < 3; i++) do_pop();
    checks++;
    if (bus.count !== 5'd0 || bus.not_empty !== 1'b0) begin
      errors++; $display("FAIL pop_empty: count=%0d ne=%b expected 0/0", bus.count, bus.not_empty);
    end
    send(8'h7E, 0, 1'b0, 1'b0);
    checks++;
    if (bus.count !== 5'd1 || bus.dout !== 8'h7E) begin
      errors++; $display("FAIL after_empty_pop: count=%0d dout=%h expected 1/7e", bus.count, bus.dout);
    end
    send(8'hC1, 0, 1'b0, 1'b0);
    send(8'hC2, 2, 1'b0, 1'b0);
    while (sb.size() > 0) do_pop();
  endtask

  task automatic test_reset_mid_ack();
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 0, 1'b0, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    @(posedge clk); #1;
    checks++;
    if (bus.count !== 5'd5 || bus.rx_rd !== 1'b1) begin
      errors++; $display("FAIL pre_reset: count=%0d rx_rd=%b expected 5/1", bus.count, bus.rx_rd);
    end
    reset = 1'b1; #1;
    sb.delete(); mov = 1'b0;
    checks++;
    if ({bus.rx_rd, bus.not_empty, bus.full, bus.overflow} !== 4'b0000 || bus.count !== 5'd0 || bus.dout !== 8'h00) begin
      errors++; $display("FAIL async_reset: rd/ne/full/ovf=%b count=%0d dout=%h expected 0000/0/00",
                         {bus.rx_rd, bus.not_empty, bus.full, bus.overflow}, bus.count, bus.dout);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    sb.push_back(8'h5A);
    checks++;
    if (bus.rx_rd !== 1'b1) begin
      errors++; $display("FAIL recapture_rd: rx_rd=%b expected 1", bus.rx_rd);
    end
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.count !== 5'd1 || bus.dout !== 8'h5A || bus.rx_rd !== 1'b0) begin
      errors++; $display("FAIL recapture: count=%0d dout=%h rx_rd=%b expected 1/5a/0", bus.count, bus.dout, bus.rx_rd);
    end
    while (sb.size() > 0) do_pop();
  endtask

`ifdef UART_RX_FIFO_WATERMARK_EN
  task automatic test_watermark();
    for (int i = 0; i < 11; i++) send(8'(8'hE0 + i), 0, 1'b0, 1'b0);
    checks++;
    if (bus.almost_full !== 1'b0) begin
      errors++; $display("FAIL wm_11: almost_full=%b expected 0", bus.almost_full);
    end
    send(8'hEB, 0, 1'b0, 1'b0);
    checks++;
    if (bus.almost_full !== 1'b1) begin
      errors++; $display("FAIL wm_12: almost_full=%b expected 1", bus.almost_full);
    end
    do_pop();
    checks++;
    if (bus.almost_full !== 1'b0) begin
      errors++; $display("FAIL wm_pop: almost_full=%b expected 0", bus.almost_full);
    end
    while (sb.size() > 0) do_pop();
  endtask
`endif

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.pop      = 1'b0;
    bus.clr_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single_byte();
    test_hold_valid();
    test_overflow();
    test_full_pop_push();
    test_pop_empty();
    test_reset_mid_ack();
`ifdef UART_RX_FIFO_WATERMARK_EN
    test_watermark();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
